toy_bus_arb_node_2to1_req: RTL and testbench
============================================

Name: toy_bus_arb_node_2to1_req

Overview:
- Two-input, one-output round-robin arbiter/merge node for the ToyBusReq payload. It is the convergence counterpart of the tgt_id-routing decode node.
- It merges request streams from two upstream sources, e.g. two decode-node outputs or an LSU and a fetch port, onto one downstream link toward a target.
- The output is registered through a full-throughput forward pipeline stage, so arbitration logic never sits combinationally in the downstream path.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with in0 always preferred.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- inN_vld  input  1  (N = 0,1) request valid from source N.
- inN_rdy  output  1  (N = 0,1) request accepted from source N.
- inN_addr  input  32  (N = 0,1) payload field.
- inN_strb  input  32  (N = 0,1) payload field.
- inN_data  input  256  (N = 0,1) payload field.
- inN_opcode  input  1  (N = 0,1) payload field.
- inN_src_id  input  4  (N = 0,1) payload field.
- inN_tgt_id  input  4  (N = 0,1) payload field.
- inN_sideband  input  10  (N = 0,1) payload field.
- out0_vld  output  1  registered request valid.
- out0_rdy  input  1  downstream ready.
- out0_addr, out0_strb, out0_data, out0_opcode, out0_src_id, out0_tgt_id, out0_sideband  output  32/32/256/1/4/4/10  registered payload, widths in field order.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out0_vld=0 and all out0 payload registers=0.
  - Priority pointer pri=0, so in0 is preferred.
  - in0_rdy and in1_rdy read 0 in any cycle while rst=1.
- Stage free: load = !out0_vld || out0_rdy.
- Grant (combinational):
  - gnt0 = in0_vld && (!in1_vld || pri==0).
  - gnt1 = in1_vld && (!in0_vld || pri==1).
  - When RR_EN=0, pri is held at 0.
- Ready:
  - inN_rdy = load && gntN.
  - At most one inN_rdy is high in any cycle.
  - in_rdy may depend on either in_vld; out0_vld never depends on out0_rdy combinationally.
- Transfer: on an edge with inN_vld && inN_rdy:
  - out0 payload <= inN payload.
  - out0_vld <= 1.
  - pri <= ~N, so the granted source becomes lowest priority.
- Drain: on an edge with out0_vld && out0_rdy and no input transfer, out0_vld <= 0. The payload registers hold their values.
- Pointer hold: pri changes only on an input transfer. An idle cycle or a single-requester cycle does not disturb fairness beyond the transfer rule.
- Latency and throughput:
  - Accepted beat appears on out0 the next cycle.
  - Sustained throughput is 1 beat/cycle when out0_rdy=1.
- Backpressure:
  - While out0_vld && !out0_rdy, out0_vld and every payload bit hold stable and both inN_rdy=0.
  - Arbitration is re-evaluated each cycle; a waiting source need not hold grant.
  - Sources must keep vld/payload stable until their rdy (standard valid/ready rule).
- Simultaneous drain and load in the same cycle: the output register is overwritten with the new beat and out0_vld stays 1. No bubble is inserted.
- Fairness: with both sources continuously valid and out0_rdy=1, grants alternate strictly 0,1,0,1...
- Starvation bound: a valid source waits at most one transfer of the other source.
- Payload is passed bit-exact and unmodified: no tgt_id decode, no field rewriting.
- Reset mid-operation: a pending out0 beat is discarded (out0_vld=0 the following cycle) and pri returns to 0. No partial state survives.

Test Plan:
- Reset, then in0 only: in0_vld=1, addr=0x1000, tgt_id=2, out0_rdy=1 -> in0_rdy=1 in cycle 0; out0_vld=1, out0_addr=0x1000, out0_tgt_id=2 in cycle 1; in1_rdy stays 0.
- Both valid for 4 cycles after reset, out0_rdy=1, in0 src_id=1, in1 src_id=5 -> out0_src_id sequence 1,5,1,5 in cycles 1-4.
- Backpressure: one beat loaded with data=0xA5A5..., out0_rdy=0 for 3 cycles while in1_vld=1 -> out0 payload unchanged and in0_rdy=in1_rdy=0 for 3 cycles; when out0_rdy=1 the same cycle accepts in1 (simultaneous drain+load) and out0_vld stays 1.
- RR_EN=0, both valid, out0_rdy=1 for 3 cycles -> only in0 granted in every cycle; in1_rdy=0 throughout.
- Reset mid-stream: out0_vld=1 with pri=1, assert rst for 1 cycle -> out0_vld=0 next cycle; after release with both valid, in0 is granted first.
- Alternating single requests (in1 then in0 then in1), each with the other idle -> each is accepted immediately with 1-cycle latency; pri toggles per transfer and never blocks a lone requester.

Source files
------------

// File: rtl/toy_bus_arb_node_2to1_req.sv
// Two-to-one request merge node: round-robin (or fixed in0-first) arbitration into a registered output stage.
// Accepted beat appears on out0 one cycle later; 1 beat/cycle sustained; both inputs stall while out0 is held.
module toy_bus_arb_node_2to1_req #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_vld,
  output logic         in0_rdy,
  input  logic [31:0]  in0_addr,
  input  logic [31:0]  in0_strb,
  input  logic [255:0] in0_data,
  input  logic         in0_opcode,
  input  logic [3:0]   in0_src_id,
  input  logic [3:0]   in0_tgt_id,
  input  logic [9:0]   in0_sideband,
  input  logic         in1_vld,
  output logic         in1_rdy,
  input  logic [31:0]  in1_addr,
  input  logic [31:0]  in1_strb,
  input  logic [255:0] in1_data,
  input  logic         in1_opcode,
  input  logic [3:0]   in1_src_id,
  input  logic [3:0]   in1_tgt_id,
  input  logic [9:0]   in1_sideband,
  output logic         out0_vld,
  input  logic         out0_rdy,
  output logic [31:0]  out0_addr,
  output logic [31:0]  out0_strb,
  output logic [255:0] out0_data,
  output logic         out0_opcode,
  output logic [3:0]   out0_src_id,
  output logic [3:0]   out0_tgt_id,
  output logic [9:0]   out0_sideband
);

  typedef struct packed {
    logic [31:0]  addr;
    logic [31:0]  strb;
    logic [255:0] data;
    logic         opcode;
    logic [3:0]   src_id;
    logic [3:0]   tgt_id;
    logic [9:0]   sideband;
  } req_t;

  req_t pay0, pay1, out_q;
  logic out_vld_q;
  logic pri;
  logic load, gnt0, gnt1;

  assign pay0 = {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband};
  assign pay1 = {in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband};

  assign load = !out_vld_q || out0_rdy;
  assign gnt0 = in0_vld && (!in1_vld || !pri);
  assign gnt1 = in1_vld && (!in0_vld || pri);

  // Gating with rst keeps sources from seeing a handshake that the reset would discard.
  assign in0_rdy = !rst && load && gnt0;
  assign in1_rdy = !rst && load && gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      pri       <= 1'b0;
    end else if (in0_rdy || in1_rdy) begin
      out_q     <= in1_rdy ? pay1 : pay0;
      out_vld_q <= 1'b1;
      // Winner drops to lowest priority: pri points at the source that lost.
      pri       <= RR_EN ? in0_rdy : 1'b0;
    end else if (out0_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out0_vld      = out_vld_q;
  assign out0_addr     = out_q.addr;
  assign out0_strb     = out_q.strb;
  assign out0_data     = out_q.data;
  assign out0_opcode   = out_q.opcode;
  assign out0_src_id   = out_q.src_id;
  assign out0_tgt_id   = out_q.tgt_id;
  assign out0_sideband = out_q.sideband;

endmodule

// File: tb/tb_toy_bus_arb_node_2to1_req.sv
// Bench for the 2:1 arbiter node: a round-robin and a fixed-priority instance share stimulus and are each
// compared every cycle against a transaction-level model, plus directed literal expectations.
module tb_toy_bus_arb_node_2to1_req;
  localparam int W = 339;

  logic clk = 1'b0;
  logic rst, out0_rdy, v0, v1;
  logic [W-1:0] p0, p1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic rr_vld, rr_rdy0, rr_rdy1, fp_vld, fp_rdy0, fp_rdy1;
  logic [31:0] rr_addr, rr_strb, fp_addr, fp_strb;
  logic [255:0] rr_data, fp_data;
  logic rr_op, fp_op;
  logic [3:0] rr_src, rr_tgt, fp_src, fp_tgt;
  logic [9:0] rr_sb, fp_sb;
  logic [W-1:0] rr_pl, fp_pl;
  assign rr_pl = {rr_addr, rr_strb, rr_data, rr_op, rr_src, rr_tgt, rr_sb};
  assign fp_pl = {fp_addr, fp_strb, fp_data, fp_op, fp_src, fp_tgt, fp_sb};

  toy_bus_arb_node_2to1_req #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .in0_vld(v0), .in0_rdy(rr_rdy0), .in0_addr(p0[338:307]), .in0_strb(p0[306:275]),
    .in0_data(p0[274:19]), .in0_opcode(p0[18]), .in0_src_id(p0[17:14]), .in0_tgt_id(p0[13:10]),
    .in0_sideband(p0[9:0]),
    .in1_vld(v1), .in1_rdy(rr_rdy1), .in1_addr(p1[338:307]), .in1_strb(p1[306:275]),
    .in1_data(p1[274:19]), .in1_opcode(p1[18]), .in1_src_id(p1[17:14]), .in1_tgt_id(p1[13:10]),
    .in1_sideband(p1[9:0]),
    .out0_vld(rr_vld), .out0_rdy(out0_rdy), .out0_addr(rr_addr), .out0_strb(rr_strb),
    .out0_data(rr_data), .out0_opcode(rr_op), .out0_src_id(rr_src), .out0_tgt_id(rr_tgt),
    .out0_sideband(rr_sb)
  );

  toy_bus_arb_node_2to1_req #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .in0_vld(v0), .in0_rdy(fp_rdy0), .in0_addr(p0[338:307]), .in0_strb(p0[306:275]),
    .in0_data(p0[274:19]), .in0_opcode(p0[18]), .in0_src_id(p0[17:14]), .in0_tgt_id(p0[13:10]),
    .in0_sideband(p0[9:0]),
    .in1_vld(v1), .in1_rdy(fp_rdy1), .in1_addr(p1[338:307]), .in1_strb(p1[306:275]),
    .in1_data(p1[274:19]), .in1_opcode(p1[18]), .in1_src_id(p1[17:14]), .in1_tgt_id(p1[13:10]),
    .in1_sideband(p1[9:0]),
    .out0_vld(fp_vld), .out0_rdy(out0_rdy), .out0_addr(fp_addr), .out0_strb(fp_strb),
    .out0_data(fp_data), .out0_opcode(fp_op), .out0_src_id(fp_src), .out0_tgt_id(fp_tgt),
    .out0_sideband(fp_sb)
  );

  // Transaction model: index 0 = round-robin instance, 1 = fixed priority.
  logic         m_vld [2];
  logic [W-1:0] m_pl  [2];
  int           m_last[2];  // source that won the last transfer, -1 after reset

  function automatic int winner(input int k, input logic a, input logic b);
    if (a && b) return (k == 0 && m_last[k] == 0) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_vld[k] = 1'b0; m_pl[k] = '0; m_last[k] = -1;
      end else begin
        int w;
        w = winner(k, v0, v1);
        if ((!m_vld[k] || out0_rdy) && w >= 0) begin
          m_pl[k] = (w == 1) ? p1 : p0;
          m_vld[k] = 1'b1;
          m_last[k] = w;
        end else if (m_vld[k] && out0_rdy) begin
          m_vld[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      logic free;
      w = winner(k, v0, v1);
      free = !rst && (!m_vld[k] || out0_rdy);
      chk(k == 0 ? "rr_vld" : "fp_vld", W'(k == 0 ? rr_vld : fp_vld), W'(m_vld[k]));
      chk(k == 0 ? "rr_payload" : "fp_payload", k == 0 ? rr_pl : fp_pl, m_pl[k]);
      chk(k == 0 ? "rr_in0_rdy" : "fp_in0_rdy", W'(k == 0 ? rr_rdy0 : fp_rdy0), W'(free && w == 0));
      chk(k == 0 ? "rr_in1_rdy" : "fp_in1_rdy", W'(k == 0 ? rr_rdy1 : fp_rdy1), W'(free && w == 1));
    end
  end

  function automatic logic [W-1:0] rnd();
    logic [351:0] t;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mk(input logic [31:0] addr, input logic [255:0] data,
                                      input logic [3:0] src, input logic [3:0] tgt);
    logic [W-1:0] t;
    t = rnd();
    t[338:307] = addr;
    t[274:19] = data;
    t[17:14] = src;
    t[13:10] = tgt;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic a0, a1;
  int rdy_pct;

  initial begin
    rst = 1'b1; out0_rdy = 1'b1; v0 = 1'b1; v1 = 1'b1; p0 = rnd(); p1 = rnd();
    a0 = 1'b0; a1 = 1'b0;
    // Reset state
    @(negedge clk);
    chk("reset_vld", W'(rr_vld), W'(0));
    chk("reset_payload", rr_pl, '0);
    chk("reset_rdy0", W'(rr_rdy0), W'(0));
    chk("reset_rdy1", W'(fp_rdy1), W'(0));
    tick();

    // Lone in0 request
    rst = 1'b0; v1 = 1'b0; p0 = mk(32'h1000, 256'h1, 4'd0, 4'd2);
    @(negedge clk);
    chk("t1_in0_rdy", W'(rr_rdy0), W'(1));
    chk("t1_in1_rdy", W'(rr_rdy1), W'(0));
    tick(); v0 = 1'b0;
    @(negedge clk);
    chk("t1_out_vld", W'(rr_vld), W'(1));
    chk("t1_out_addr", W'(rr_addr), W'(32'h1000));
    chk("t1_out_tgt", W'(rr_tgt), W'(2));
    chk("t1_fp_addr", W'(fp_addr), W'(32'h1000));
    tick(); rst = 1'b1; tick();

    // Both valid: alternation vs fixed priority
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
    p0 = mk(32'h10, 256'h2, 4'd1, 4'd0); p1 = mk(32'h20, 256'h3, 4'd5, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      chk("t2_rr_src", W'(rr_src), W'((i % 2 == 1) ? 4'd1 : 4'd5));
      chk("t2_fp_src", W'(fp_src), W'(4'd1));
      chk("t2_fp_in1_rdy", W'(fp_rdy1), W'(0));
    end
    tick(); rst = 1'b1; v0 = 1'b0; v1 = 1'b0; tick();

    // Backpressure then simultaneous drain+load
    rst = 1'b0; v0 = 1'b1; out0_rdy = 1'b0;
    p0 = mk(32'h30, {8{32'hA5A5A5A5}}, 4'd2, 4'd1);
    tick(); v0 = 1'b0; v1 = 1'b1;
    p1 = mk(32'h40, {8{32'h5A5A5A5A}}, 4'd5, 4'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_data", W'(rr_data), W'({8{32'hA5A5A5A5}}));
      chk("t3_hold_vld", W'(rr_vld), W'(1));
      chk("t3_hold_rdy", W'({rr_rdy0, rr_rdy1}), W'(0));
      tick();
    end
    out0_rdy = 1'b1;
    @(negedge clk);
    chk("t3_dl_in1_rdy", W'(rr_rdy1), W'(1));
    tick(); v1 = 1'b0;
    @(negedge clk);
    chk("t3_dl_vld", W'(rr_vld), W'(1));
    chk("t3_dl_data", W'(rr_data), W'({8{32'h5A5A5A5A}}));
    tick(); rst = 1'b1; tick();

    // Reset mid-stream with pri pointing at in1
    rst = 1'b0; v0 = 1'b1; out0_rdy = 1'b0; p0 = mk(32'h50, 256'h5, 4'd3, 4'd0);
    tick(); v0 = 1'b0;
    @(negedge clk);
    chk("t5_vld_before", W'(rr_vld), W'(1));
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; v0 = 1'b1; v1 = 1'b1; out0_rdy = 1'b1; p0 = rnd(); p1 = rnd();
    @(negedge clk);
    chk("t5_vld_after", W'(rr_vld), W'(0));
    chk("t5_in0_first", W'({rr_rdy0, rr_rdy1}), W'(2'b10));
    tick(); v0 = 1'b0; v1 = 1'b0; rst = 1'b1; tick();

    // Alternating lone requesters
    rst = 1'b0; v1 = 1'b1; p1 = mk(32'h60, 256'h6, 4'd9, 4'd1);
    @(negedge clk);
    chk("t6_a_rdy", W'({rr_rdy0, rr_rdy1}), W'(2'b01));
    tick(); v1 = 1'b0; v0 = 1'b1; p0 = mk(32'h70, 256'h7, 4'd3, 4'd1);
    @(negedge clk);
    chk("t6_a_src", W'(rr_src), W'(4'd9));
    chk("t6_b_rdy", W'({rr_rdy0, rr_rdy1}), W'(2'b10));
    tick(); v0 = 1'b0; v1 = 1'b1; p1 = mk(32'h80, 256'h8, 4'd7, 4'd1);
    @(negedge clk);
    chk("t6_b_src", W'(rr_src), W'(4'd3));
    chk("t6_c_rdy", W'({rr_rdy0, rr_rdy1}), W'(2'b01));
    tick(); v1 = 1'b0;
    @(negedge clk);
    chk("t6_c_src", W'(rr_src), W'(4'd7));
    chk("t6_c_vld", W'(rr_vld), W'(1));
    tick();

    // Randomized traffic; sources hold their beat until the round-robin instance takes it
    for (int n = 0; n < 3000; n++) begin
      rdy_pct = (n < 1000) ? 100 : (n < 2000) ? 50 : 80;
      rst = ($urandom_range(0, 199) == 0);
      out0_rdy = ($urandom_range(1, 100) <= rdy_pct);
      if (!v0 || a0) begin v0 = ($urandom_range(0, 2) != 0); p0 = rnd(); end
      if (!v1 || a1) begin v1 = ($urandom_range(0, 2) != 0); p1 = rnd(); end
      @(negedge clk);
      a0 = v0 && rr_rdy0;
      a1 = v1 && rr_rdy1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
